// File: rtl/shift_rows_pkg.sv
// Shared definitions for the ShiftRows pipeline: mode encoding, legal state
// widths and the per-row byte rotation amount.
package shift_rows_pkg;

   typedef enum logic {
      MODE_ENC = 1'b0,
      MODE_DEC = 1'b1
   } mode_e;

   function automatic bit nb_is_legal(input int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   // Rows 2 and 3 of the 256-bit state rotate one byte further than the narrower states.
   function automatic int row_offset(input int nb, input int r);
      return ((nb == 8) && (r >= 2)) ? r + 1 : r;
   endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Purely combinational ShiftRows / InvShiftRows byte permutation of a
// row-major state (row r at din[W-1-r*RB -: RB], column 0 in the top byte).
module shift_rows_perm
   import shift_rows_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic              mode,
   input  logic [NB*32-1:0]  din,
   output logic [NB*32-1:0]  dout
);

   localparam int W  = NB * 32;
   localparam int RB = NB * 8;

   logic [W-1:0] w_enc;
   logic [W-1:0] w_dec;

   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int C = row_offset(NB, r);
      for (genvar c = 0; c < NB; c++) begin : g_col
         // Encrypt takes column c from c+C (left rotate); decrypt from c-C (right rotate).
         assign w_enc[W-1-r*RB-c*8 -: 8] = din[W-1-r*RB-((c+C)%NB)*8 -: 8];
         assign w_dec[W-1-r*RB-c*8 -: 8] = din[W-1-r*RB-((c+NB-C)%NB)*8 -: 8];
      end
   end

   assign dout = (mode == MODE_DEC) ? w_dec : w_enc;

endmodule

// File: rtl/shift_rows_pipe.sv
// One-cycle ShiftRows stage with a two-entry (output + skid) valid/ready buffer;
// the permutation is applied before the words are stored.
module shift_rows_pipe
   import shift_rows_pkg::*;
#(
   parameter int NB = 4,
   localparam int W  = NB * 32,
   localparam int RB = NB * 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_mode,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_mode,
   output logic [W-1:0]  out_data
);

   if (!nb_is_legal(NB)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end

   logic [W-1:0] w_perm;
   logic         w_accept;
   logic         w_out_free;
   logic         w_load_from_skid;
   logic         w_load_from_in;
   logic         w_load_skid;
   logic         w_skid_valid_nxt;

   logic         r_out_valid;
   logic         r_out_mode;
   logic [W-1:0] r_out_data;
   logic         r_skid_valid;
   logic         r_skid_mode;
   logic [W-1:0] r_skid_data;
   logic         r_in_ready;

   shift_rows_perm #(.NB(NB)) u_perm (
      .mode (in_mode),
      .din  (in_data),
      .dout (w_perm)
   );

   // The skid entry always drains first, so words leave in arrival order.
   assign w_accept         = in_valid && r_in_ready;
   assign w_out_free       = !r_out_valid || out_ready;
   assign w_load_from_skid = w_out_free && r_skid_valid;
   assign w_load_from_in   = w_out_free && !r_skid_valid && w_accept;
   assign w_load_skid      = !w_out_free && w_accept;
   assign w_skid_valid_nxt = w_load_skid || (r_skid_valid && !w_out_free);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b0;
      end else begin
         if (w_out_free) begin
            r_out_valid <= r_skid_valid || w_accept;
         end
         r_skid_valid <= w_skid_valid_nxt;
         r_in_ready   <= !w_skid_valid_nxt;
      end
   end

   // NOTE: data registers are deliberately not reset; the valid flags qualify them.
   always_ff @(posedge clk) begin
      if (w_load_from_skid) begin
         r_out_data <= r_skid_data;
         r_out_mode <= r_skid_mode;
      end else if (w_load_from_in) begin
         r_out_data <= w_perm;
         r_out_mode <= in_mode;
      end
      if (w_load_skid) begin
         r_skid_data <= w_perm;
         r_skid_mode <= in_mode;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_mode  = r_out_mode;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: directed vectors for NB=4 and NB=8,
// back-pressure, reset flush and a randomized scoreboard run.
module tb_shift_rows_pipe;

   localparam int W4 = 128;
   localparam int W8 = 256;
   localparam int N_WORDS = 10000;

   typedef struct {
      logic [W4-1:0] din;
      logic          mode;
   } word_t;

   logic          clk = 1'b0;
   logic          rst;

   logic          in_valid, in_ready, in_mode;
   logic [W4-1:0] in_data;
   logic          out_valid, out_ready, out_mode;
   logic [W4-1:0] out_data;

   logic          in_valid8, in_ready8, in_mode8;
   logic [W8-1:0] in_data8;
   logic          out_valid8, out_ready8, out_mode8;
   logic [W8-1:0] out_data8;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   shift_rows_pipe #(.NB(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mode  (out_mode),
      .out_data  (out_data)
   );

   shift_rows_pipe #(.NB(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .in_mode   (in_mode8),
      .in_data   (in_data8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .out_mode  (out_mode8),
      .out_data  (out_data8)
   );

   // Reference: split into rows, rotate each row one byte at a time Cr times.
   function automatic logic [255:0] model(input int nb, input logic mode, input logic [255:0] d);
      int            rb;
      int            c;
      logic [255:0]  mask;
      logic [255:0]  row;
      logic [255:0]  res;
      rb   = nb * 8;
      mask = (256'd1 << rb) - 256'd1;
      res  = '0;
      for (int r = 0; r < 4; r++) begin
         c   = (nb == 8 && r >= 2) ? r + 1 : r;
         row = (d >> ((3 - r) * rb)) & mask;
         for (int k = 0; k < c; k++) begin
            if (!mode) row = ((row << 8) | (row >> (rb - 8))) & mask;
            else       row = ((row >> 8) | (row << (rb - 8))) & mask;
         end
         res = res | (row << ((3 - r) * rb));
      end
      return res;
   endfunction

   function automatic logic [W4-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
      in_valid8 = 1'b0; in_mode8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
      else n_pass++;
      rst = 1'b0;
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      else n_pass++;
   endtask

   task automatic test_vectors();
      logic [W4-1:0] v_plain  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
      logic [W4-1:0] v_cipher = 128'h00010203_05060704_0A0B0809_0F0C0D0E;
      logic [W8-1:0] v8_in  = {64'h0001020304050607, 64'h08090A0B0C0D0E0F,
                               64'h1011121314151617, 64'h18191A1B1C1D1E1F};
      logic [W8-1:0] v8_out = {64'h0001020304050607, 64'h090A0B0C0D0E0F08,
                               64'h1314151617101112, 64'h1C1D1E1F18191A1B};
      out_ready = 1'b1;
      in_valid = 1'b1; in_mode = 1'b0; in_data = v_plain;
      in_valid8 = 1'b1; in_mode8 = 1'b0; in_data8 = v8_in;
      tick();
      in_mode = 1'b1; in_data = v_cipher;
      in_valid8 = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== v_cipher || out_mode !== 1'b0)
         $display("FAIL vec_nb4_enc: valid=%b data=%h want 1/%h", out_valid, out_data, v_cipher);
      else n_pass++;
      n_checks++;
      if (out_valid8 !== 1'b1 || out_data8 !== v8_out)
         $display("FAIL vec_nb8_enc: valid=%b data=%h want 1/%h", out_valid8, out_data8, v8_out);
      else n_pass++;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== v_plain || out_mode !== 1'b1)
         $display("FAIL vec_nb4_dec: valid=%b data=%h want 1/%h", out_valid, out_data, v_plain);
      else n_pass++;
      in_valid8 = 1'b1; in_mode8 = 1'b1; in_data8 = v8_out;
      tick();
      in_valid8 = 1'b0;
      n_checks++;
      if (out_valid8 !== 1'b1 || out_data8 !== v8_in || out_mode8 !== 1'b1)
         $display("FAIL vec_nb8_dec: valid=%b data=%h want 1/%h", out_valid8, out_data8, v8_in);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_valid8 !== 1'b0)
         $display("FAIL vec_drain: out_valid=%b out_valid8=%b want 0/0", out_valid, out_valid8);
      else n_pass++;
   endtask

   task automatic test_back_pressure();
      word_t w[3];
      logic [W4-1:0] exp_a, exp_b, exp_c;
      for (int i = 0; i < 3; i++) begin
         w[i].din  = rand128();
         w[i].mode = 1'($urandom_range(0, 1));
      end
      exp_a = model(4, w[0].mode, w[0].din);
      exp_b = model(4, w[1].mode, w[1].din);
      exp_c = model(4, w[2].mode, w[2].din);
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = w[0].mode; in_data = w[0].din;
      tick();
      in_mode = w[1].mode; in_data = w[1].din;
      tick();
      in_mode = w[2].mode; in_data = w[2].din;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_a)
            $display("FAIL bp_stall[%0d]: in_ready=%b data=%h want 0/%h", i, in_ready, out_data, exp_a);
         else n_pass++;
         tick();
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_b || in_ready !== 1'b1)
         $display("FAIL bp_second: data=%h in_ready=%b want %h/1", out_data, in_ready, exp_b);
      else n_pass++;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_c || out_mode !== w[2].mode)
         $display("FAIL bp_third: data=%h want %h", out_data, exp_c);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_reset_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 1'b0; in_data = rand128();
      tick();
      in_data = rand128();
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL flush_full: in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
      else n_pass++;
      rst = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL flush_rst: out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
      else n_pass++;
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL flush_release: in_ready=%b want 1", in_ready);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_valid !== 1'b0) $display("FAIL flush_ghost[%0d]: out_valid=%b want 0", i, out_valid);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_random();
      word_t         sb[$];
      word_t         exp;
      logic [W4-1:0] exp_out;
      int            sent = 0;
      int            received = 0;
      int            cycles = 0;
      int            errs = 0;
      while (received < N_WORDS && cycles < 60000) begin
         in_valid  = (sent < N_WORDS) && ($urandom_range(0, 3) != 0);
         in_mode   = 1'($urandom_range(0, 1));
         in_data   = rand128();
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               $display("FAIL rand_extra: unexpected word %h", out_data);
               errs++;
            end else begin
               exp     = sb.pop_front();
               exp_out = model(4, exp.mode, exp.din);
               if (out_data !== exp_out || out_mode !== exp.mode) begin
                  if (errs < 10)
                     $display("FAIL rand_word[%0d]: got %h/%b want %h/%b",
                              received, out_data, out_mode, exp_out, exp.mode);
                  errs++;
               end else if (model(4, ~out_mode, out_data) !== exp.din) begin
                  if (errs < 10)
                     $display("FAIL rand_roundtrip[%0d]: got %h want %h",
                              received, model(4, ~out_mode, out_data), exp.din);
                  errs++;
               end else n_pass++;
            end
            received++;
         end
         if (in_valid && in_ready) begin
            sb.push_back('{din: in_data, mode: in_mode});
            sent++;
         end
         tick();
         cycles++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (received != N_WORDS || sb.size() != 0)
         $display("FAIL rand_count: received %0d pending %0d want %0d/0", received, sb.size(), N_WORDS);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_pressure();
      test_reset_flush();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, giving the state width in 32-bit columns; legal values are 4, 6 and 8, and any other value is an elaboration error.
REQ-002 SHALL have derived localparam W = NB*32 (state width) and RB = NB*8 (row width in bits).
REQ-003 SHALL have one clock and a synchronous, active-high reset; the clock is the only clock.
REQ-004 Ports, in order (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  block can accept an input word
- in_mode  in  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt)
- in_data  in  W  input state
- out_valid  out  1  output word present
- out_ready  in  1  consumer accepts the output word
- out_mode  out  1  in_mode that travelled with the word
- out_data  out  W  permuted state

Function
REQ-005 State layout SHALL be row-major: row r (r = 0..3) occupies in_data[W-1-r*RB -: RB], with the most significant byte of each row as column 0.
REQ-006 Row shift offsets SHALL be (C0,C1,C2,C3) = (0,1,2,3) bytes for NB = 4 or 6, and (0,1,3,4) bytes for NB = 8.
REQ-007 Encrypt mode SHALL rotate row r left by Cr bytes; decrypt mode SHALL rotate row r right by Cr bytes. Row 0 SHALL pass through unchanged in both modes.
REQ-008 An input transfer SHALL occur on a clk edge where in_valid && in_ready; an output transfer SHALL occur on a clk edge where out_valid && out_ready.
REQ-009 Latency SHALL be 1 cycle: a word transferred in at edge N SHALL appear on out_data/out_mode with out_valid = 1 after edge N. No combinational path SHALL exist from in_* to out_*.
REQ-010 Buffering SHALL be two entries: an output register plus one skid register. in_ready SHALL be a register output, equal to "skid register empty".
REQ-011 Sustained throughput SHALL be one word per cycle whenever out_ready is held at 1.
REQ-012 While out_valid = 1 and out_ready = 0, out_data and out_mode SHALL remain stable.
REQ-013 When the output register is full, out_ready = 0 and a word is accepted, that word SHALL go to the skid register and in_ready SHALL drop after that edge.
REQ-014 When the skid register is full and out_ready = 1, the skid entry SHALL move to the output register on that edge, and in_ready SHALL rise after it.
REQ-015 An accept and a take on the same edge SHALL neither lose nor duplicate a word, and words SHALL leave in arrival order.
REQ-016 mode SHALL be sampled per word; consecutive words with different modes SHALL each be permuted according to their own mode.
REQ-017 Occupancy SHALL go 0 -> 1 -> 2 only; in_ready = 0 at occupancy 2; out_valid = 0 at occupancy 0.

Reset
REQ-018 While rst = 1: out_valid = 0, in_ready = 0, and both buffer entries are marked empty. After the first clk edge with rst = 0, in_ready = 1.
REQ-019 rst asserted mid-operation SHALL discard all buffered words at the next clk edge; discarded words SHALL never appear on the output.
REQ-020 Data registers need not be reset; out_data is don't-care while out_valid = 0.

Structure
REQ-021 Package shift_rows_pkg SHALL hold the mode encoding (MODE_ENC = 0, MODE_DEC = 1), the legal-NB check and a function returning Cr for a given (NB, r).
REQ-022 The permutation SHALL live in one purely combinational sub-module, shift_rows_perm (parameter NB; ports mode, din, dout), instantiated on the input side ahead of the buffering.

Verification
REQ-023 NB=4, enc, in_data 00010203_04050607_08090A0B_0C0D0E0F -> out_data 00010203_05060704_0A0B0809_0F0C0D0E, out_valid one cycle after the input transfer.
REQ-024 NB=4, dec, in_data 00010203_05060704_0A0B0809_0F0C0D0E -> out_data 00010203_04050607_08090A0B_0C0D0E0F.
REQ-025 NB=8, enc, rows 0001..07 / 0809..0F / 1011..17 / 1819..1F -> rows unchanged / 090A0B0C0D0E0F08 / 1314151617101112 / 1C1D1E1F18191A1B.
REQ-026 Back-pressure: out_ready = 0 while 3 words are offered -> exactly 2 accepted, in_ready = 0, out_data stable; then out_ready = 1 -> both delivered in order, the third accepted.
REQ-027 Random valid/ready with random mode for 10k words against a reference model -> order preserved, every word correct, no loss or duplication, and enc-then-dec round trip equals the original input.
REQ-028 rst pulsed with 2 words buffered -> out_valid = 0 after that edge, in_ready = 1 one cycle after release, neither discarded word ever emitted.
